// File: rtl/box_track_ctrl.sv
// box_track_ctrl: confirms, smooths and holds the detector's per-frame bounding box for the overlay stage.
// Revision 1.0
`default_nettype none

module box_track_ctrl #(
  parameter int MIN_W          = 8,
  parameter int MIN_H          = 8,
  parameter int CONFIRM_FRAMES = 3,
  parameter int HOLD_FRAMES    = 15,
  parameter int SMOOTH_SHIFT   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trk_en,
  input  logic        frame_done,
  input  logic        box_flag,
  input  logic [10:0] box_top,
  input  logic [10:0] box_bottom,
  input  logic [10:0] box_left,
  input  logic [10:0] box_right,
  output logic        trk_valid,
  output logic [10:0] trk_top,
  output logic [10:0] trk_bottom,
  output logic [10:0] trk_left,
  output logic [10:0] trk_right,
  output logic [1:0]  trk_state,
  output logic        update_pulse,
  output logic        lost_pulse
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONFIRM = 2'd1,
    TRACK   = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam logic [11:0] MIN_W_V  = 12'(MIN_W);
  localparam logic [11:0] MIN_H_V  = 12'(MIN_H);
  localparam logic [3:0]  CONF_N   = 4'(CONFIRM_FRAMES);
  localparam logic [7:0]  HOLD_N   = 8'(HOLD_FRAMES);

  state_t      state, nxt_state;
  logic [3:0]  conf_cnt, nxt_conf;
  logic [7:0]  miss_cnt, nxt_miss;
  logic        nxt_valid, nxt_update, nxt_lost;
  logic [10:0] nxt_top, nxt_bottom, nxt_left, nxt_right;

  logic        s1_valid, s1_flag;
  logic [10:0] s1_top, s1_bottom, s1_left, s1_right;

  // Stage 1: sample the detector result on the end-of-frame strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_flag   <= 1'b0;
      s1_top    <= '0;
      s1_bottom <= '0;
      s1_left   <= '0;
      s1_right  <= '0;
    end else if (!trk_en) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= frame_done;
      if (frame_done) begin
        s1_flag   <= box_flag;
        s1_top    <= box_top;
        s1_bottom <= box_bottom;
        s1_left   <= box_left;
        s1_right  <= box_right;
      end
    end
  end

  logic [11:0] height, width;
  logic        hit;

  assign height = {1'b0, s1_bottom} - {1'b0, s1_top} + 12'd1;
  assign width  = {1'b0, s1_right} - {1'b0, s1_left} + 12'd1;
  assign hit    = s1_flag && (s1_bottom >= s1_top) && (s1_right >= s1_left) &&
                  (height >= MIN_H_V) && (width >= MIN_W_V);

  // The smoothed value always lies between old and raw, so 11 bits suffice.
  function automatic logic [10:0] smooth(input logic [10:0] old_v, input logic [10:0] raw_v);
    logic signed [11:0] diff;
    logic signed [11:0] step;
    diff = $signed({1'b0, raw_v}) - $signed({1'b0, old_v});
    step = diff >>> SMOOTH_SHIFT;
    return 11'({1'b0, old_v} + $unsigned(step));
  endfunction

  logic [10:0] sm_top, sm_bottom, sm_left, sm_right;

  assign sm_top    = smooth(trk_top, s1_top);
  assign sm_bottom = smooth(trk_bottom, s1_bottom);
  assign sm_left   = smooth(trk_left, s1_left);
  assign sm_right  = smooth(trk_right, s1_right);

  logic drop, load_raw, load_smooth;

  always_comb begin
    nxt_state   = state;
    nxt_conf    = conf_cnt;
    nxt_miss    = miss_cnt;
    nxt_valid   = trk_valid;
    nxt_top     = trk_top;
    nxt_bottom  = trk_bottom;
    nxt_left    = trk_left;
    nxt_right   = trk_right;
    nxt_update  = 1'b0;
    nxt_lost    = 1'b0;
    drop        = 1'b0;
    load_raw    = 1'b0;
    load_smooth = 1'b0;

    if (!trk_en) begin
      nxt_state  = IDLE;
      nxt_conf   = '0;
      nxt_miss   = '0;
      nxt_valid  = 1'b0;
      nxt_top    = '0;
      nxt_bottom = '0;
      nxt_left   = '0;
      nxt_right  = '0;
    end else if (s1_valid) begin
      nxt_update = 1'b1;
      case (state)
        IDLE: begin
          if (hit) begin
            if (CONF_N == 4'd1) begin
              nxt_state = TRACK;
              nxt_conf  = '0;
              load_raw  = 1'b1;
            end else begin
              nxt_state = CONFIRM;
              nxt_conf  = 4'd1;
            end
          end
        end
        CONFIRM: begin
          if (hit) begin
            if (conf_cnt + 4'd1 == CONF_N) begin
              nxt_state = TRACK;
              nxt_conf  = '0;
              load_raw  = 1'b1;
            end else begin
              nxt_conf = conf_cnt + 4'd1;
            end
          end else begin
            nxt_state = IDLE;
            nxt_conf  = '0;
          end
        end
        TRACK: begin
          if (hit) begin
            load_smooth = 1'b1;
          end else if (HOLD_N == 8'd0) begin
            drop = 1'b1;
          end else begin
            nxt_state = HOLD;
            nxt_miss  = 8'd1;
          end
        end
        HOLD: begin
          if (hit) begin
            nxt_state   = TRACK;
            nxt_miss    = '0;
            load_smooth = 1'b1;
          end else if (miss_cnt == HOLD_N) begin
            drop = 1'b1;
          end else begin
            nxt_miss = miss_cnt + 8'd1;
          end
        end
        default: nxt_state = IDLE;
      endcase

      if (load_raw) begin
        nxt_valid  = 1'b1;
        nxt_top    = s1_top;
        nxt_bottom = s1_bottom;
        nxt_left   = s1_left;
        nxt_right  = s1_right;
      end
      if (load_smooth) begin
        nxt_top    = sm_top;
        nxt_bottom = sm_bottom;
        nxt_left   = sm_left;
        nxt_right  = sm_right;
      end
      if (drop) begin
        nxt_state  = IDLE;
        nxt_conf   = '0;
        nxt_miss   = '0;
        nxt_valid  = 1'b0;
        nxt_top    = '0;
        nxt_bottom = '0;
        nxt_left   = '0;
        nxt_right  = '0;
        nxt_lost   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      conf_cnt     <= '0;
      miss_cnt     <= '0;
      trk_valid    <= 1'b0;
      trk_top      <= '0;
      trk_bottom   <= '0;
      trk_left     <= '0;
      trk_right    <= '0;
      update_pulse <= 1'b0;
      lost_pulse   <= 1'b0;
    end else begin
      state        <= nxt_state;
      conf_cnt     <= nxt_conf;
      miss_cnt     <= nxt_miss;
      trk_valid    <= nxt_valid;
      trk_top      <= nxt_top;
      trk_bottom   <= nxt_bottom;
      trk_left     <= nxt_left;
      trk_right    <= nxt_right;
      update_pulse <= nxt_update;
      lost_pulse   <= nxt_lost;
    end
  end

  assign trk_state = state;

endmodule

`default_nettype wire

// File: tb/tb_box_track_ctrl.sv
// tb_box_track_ctrl: scoreboard bench for box_track_ctrl against a frame-level reference model.
`default_nettype none

module tb_box_track_ctrl;

  localparam int MIN_W = 8;
  localparam int MIN_H = 8;
  localparam int CONFIRM_FRAMES = 3;
  localparam int HOLD_FRAMES = 15;
  localparam int SMOOTH_SHIFT = 1;

  logic        clk = 1'b0;
  logic        rst, trk_en, frame_done, box_flag;
  logic [10:0] box_top, box_bottom, box_left, box_right;
  logic        trk_valid, update_pulse, lost_pulse;
  logic [10:0] trk_top, trk_bottom, trk_left, trk_right;
  logic [1:0]  trk_state;

  box_track_ctrl #(
    .MIN_W(MIN_W), .MIN_H(MIN_H), .CONFIRM_FRAMES(CONFIRM_FRAMES),
    .HOLD_FRAMES(HOLD_FRAMES), .SMOOTH_SHIFT(SMOOTH_SHIFT)
  ) dut (
    .clk(clk), .rst(rst), .trk_en(trk_en), .frame_done(frame_done),
    .box_flag(box_flag), .box_top(box_top), .box_bottom(box_bottom),
    .box_left(box_left), .box_right(box_right), .trk_valid(trk_valid),
    .trk_top(trk_top), .trk_bottom(trk_bottom), .trk_left(trk_left),
    .trk_right(trk_right), .trk_state(trk_state),
    .update_pulse(update_pulse), .lost_pulse(lost_pulse)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int cyc; int st; int vld; int t; int b; int l; int r; int lost;
  } exp_t;
  exp_t q[$];

  // Reference model: one call per frame, following the tracking rules directly.
  int m_st, m_conf, m_miss, m_vld, m_t, m_b, m_l, m_r;

  task automatic model_reset();
    m_st = 0; m_conf = 0; m_miss = 0; m_vld = 0;
    m_t = 0; m_b = 0; m_l = 0; m_r = 0;
  endtask

  function automatic int smooth_ref(input int old, input int raw);
    int d = raw - old;
    int den = 1 << SMOOTH_SHIFT;
    int st;
    if (d >= 0) st = d / den;
    else st = -((-d + den - 1) / den);
    return old + st;
  endfunction

  task automatic model_frame(input bit flag, input int t, input int b, input int l, input int r);
    bit hit, lost, drop;
    hit = flag && (b >= t) && (r >= l) && (b - t + 1 >= MIN_H) && (r - l + 1 >= MIN_W);
    lost = 0; drop = 0;
    if (m_st == 0) begin
      if (hit) begin
        m_conf = 1;
        m_st = 1;
      end
      if (hit && CONFIRM_FRAMES == 1) begin
        m_st = 2; m_vld = 1; m_t = t; m_b = b; m_l = l; m_r = r;
      end
    end else if (m_st == 1) begin
      if (!hit) begin
        m_st = 0; m_conf = 0;
      end else begin
        m_conf++;
        if (m_conf == CONFIRM_FRAMES) begin
          m_st = 2; m_vld = 1; m_t = t; m_b = b; m_l = l; m_r = r;
        end
      end
    end else begin
      if (hit) begin
        m_st = 2; m_miss = 0;
        m_t = smooth_ref(m_t, t); m_b = smooth_ref(m_b, b);
        m_l = smooth_ref(m_l, l); m_r = smooth_ref(m_r, r);
      end else if (m_st == 2) begin
        if (HOLD_FRAMES == 0) drop = 1;
        else begin m_st = 3; m_miss = 1; end
      end else if (m_miss == HOLD_FRAMES) begin
        drop = 1;
      end else begin
        m_miss++;
      end
    end
    if (drop) begin
      model_reset();
      lost = 1;
    end
    q.push_back('{cyc + 2, m_st, m_vld, m_t, m_b, m_l, m_r, int'(lost)});
  endtask

  // Monitor: every update pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (update_pulse) begin
        if (q.size() == 0) begin
          chk("unexpected_update", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("latency_cycle", cyc, e.cyc);
          chk("state", int'(trk_state), e.st);
          chk("valid", int'(trk_valid), e.vld);
          chk("top", int'(trk_top), e.t);
          chk("bottom", int'(trk_bottom), e.b);
          chk("left", int'(trk_left), e.l);
          chk("right", int'(trk_right), e.r);
          chk("lost_pulse", int'(lost_pulse), e.lost);
        end
      end else if (lost_pulse) begin
        chk("lost_without_update", 1, 0);
      end
    end
  end

  task automatic issue(input bit flag, input int t, input int b, input int l, input int r,
                       input bit push);
    @(negedge clk);
    frame_done = 1'b1;
    box_flag   = flag;
    box_top    = 11'(t);
    box_bottom = 11'(b);
    box_left   = 11'(l);
    box_right  = 11'(r);
    if (push) model_frame(flag, t, b, l, r);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      frame_done = 1'b0;
      box_flag   = 1'b0;
    end
  endtask

  task automatic hit_box(input int t, input int b, input int l, input int r);
    issue(1'b1, t, b, l, r, 1'b1);
    idle(2);
  endtask

  task automatic clear_by_enable();
    @(negedge clk);
    trk_en = 1'b0;
    frame_done = 1'b0;
    @(negedge clk);
    trk_en = 1'b1;
    model_reset();
  endtask

  task automatic chk_box(input string name, input int t, input int b, input int l, input int r);
    chk({name, "_top"}, int'(trk_top), t);
    chk({name, "_bottom"}, int'(trk_bottom), b);
    chk({name, "_left"}, int'(trk_left), l);
    chk({name, "_right"}, int'(trk_right), r);
  endtask

  initial begin
    rst = 1'b1; trk_en = 1'b1; frame_done = 1'b0; box_flag = 1'b0;
    box_top = '0; box_bottom = '0; box_left = '0; box_right = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", int'(trk_state), 0);
    chk("reset_valid", int'(trk_valid), 0);
    chk("reset_update", int'(update_pulse), 0);
    chk_box("reset", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // Confirmation sequence.
    hit_box(100, 200, 300, 450);
    chk("confirm1_state", int'(trk_state), 1);
    hit_box(100, 200, 300, 450);
    chk("confirm2_state", int'(trk_state), 1);
    hit_box(100, 200, 300, 450);
    chk("confirm3_state", int'(trk_state), 2);
    chk("confirm3_valid", int'(trk_valid), 1);
    chk_box("confirm", 100, 200, 300, 450);

    hit_box(110, 210, 290, 460);
    chk_box("smooth", 105, 205, 295, 455);

    // Floor behaviour of the smoothing step from a known starting box.
    clear_by_enable();
    chk("en_clear_state", int'(trk_state), 0);
    repeat (3) hit_box(100, 200, 300, 450);
    hit_box(101, 200, 300, 450);
    chk("floor_up_top", int'(trk_top), 100);
    hit_box(99, 200, 300, 450);
    chk("floor_down_top", int'(trk_top), 99);

    // Undersized box is rejected but still counts as a processed frame.
    clear_by_enable();
    issue(1'b1, 10, 15, 20, 40, 1'b1);
    idle(2);
    chk("size_reject_state", int'(trk_state), 0);
    chk("size_reject_update", int'(update_pulse), 1);
    chk("size_reject_valid", int'(trk_valid), 0);

    // Hold through 15 misses, drop on the 16th.
    repeat (3) hit_box(100, 200, 300, 450);
    repeat (15) issue(1'b0, 0, 0, 0, 0, 1'b1);
    idle(2);
    chk("hold_state", int'(trk_state), 3);
    chk("hold_valid", int'(trk_valid), 1);
    chk_box("hold", 100, 200, 300, 450);
    issue(1'b0, 0, 0, 0, 0, 1'b1);
    idle(2);
    chk("timeout_state", int'(trk_state), 0);
    chk("timeout_lost", int'(lost_pulse), 1);
    chk_box("timeout", 0, 0, 0, 0);

    // Recovery at miss 10 restarts the miss count.
    repeat (3) hit_box(100, 200, 300, 450);
    repeat (10) issue(1'b0, 0, 0, 0, 0, 1'b1);
    hit_box(100, 200, 300, 450);
    chk("recover_state", int'(trk_state), 2);
    repeat (15) issue(1'b0, 0, 0, 0, 0, 1'b1);
    idle(2);
    chk("recover_hold_state", int'(trk_state), 3);

    // Disable during HOLD clears without a lost pulse.
    @(negedge clk);
    trk_en = 1'b0;
    @(negedge clk);
    chk("dis_state", int'(trk_state), 0);
    chk("dis_valid", int'(trk_valid), 0);
    chk("dis_lost", int'(lost_pulse), 0);
    chk_box("dis", 0, 0, 0, 0);
    trk_en = 1'b1;
    model_reset();

    // Disable overrides an in-flight stage-2 update.
    issue(1'b1, 100, 200, 300, 450, 1'b0);
    @(negedge clk);
    frame_done = 1'b0;
    trk_en = 1'b0;
    @(negedge clk);
    chk("inflight_update", int'(update_pulse), 0);
    chk("inflight_state", int'(trk_state), 0);
    trk_en = 1'b1;

    // Async reset mid-CONFIRM.
    hit_box(100, 200, 300, 450);
    chk("pre_rst_state", int'(trk_state), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_state", int'(trk_state), 0);
    chk("async_rst_update", int'(update_pulse), 0);
    q.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Randomized frames, including back-to-back strobes and long miss runs.
    for (int blk = 0; blk < 12; blk++) begin
      int pmiss;
      pmiss = int'($urandom_range(5, 90));
      for (int i = 0; i < 60; i++) begin
        if ($urandom_range(0, 99) < 45) begin
          int t, b, l, r, h, w;
          bit flag;
          flag = ($urandom_range(0, 99) >= pmiss);
          h = int'($urandom_range(0, 40));
          w = int'($urandom_range(0, 40));
          t = int'($urandom_range(1, 1990));
          l = int'($urandom_range(1, 1990));
          b = t + h - 1;
          r = l + w - 1;
          if ($urandom_range(0, 9) == 0) begin
            b = int'($urandom_range(0, 2047));
            r = int'($urandom_range(0, 2047));
          end
          issue(flag, t, b, l, r, 1'b1);
        end else begin
          idle(1);
        end
      end
    end

    idle(1);
    for (int k = 0; k < 10 && q.size() != 0; k++) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
